// File: rtl/alu_operand_loader_pkg.sv
// Shared types and constants for the ALU operand loader.
// Contents: loader FSM state encoding, 3-bit ALU select codes, operand and
// counter widths, and the packed operation payload driven to the ALU stage.
package alu_operand_loader_pkg;

  localparam int unsigned OPERAND_W = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned DONE_W    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD_A = 2'b01,
    LOAD_B = 2'b10,
    ISSUE  = 2'b11
  } state_e;

  typedef enum logic [SEL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_NOT = 3'b010,
    ALU_AND = 3'b011,
    ALU_OR  = 3'b100,
    ALU_XOR = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_sel_e;

  typedef struct packed {
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
    logic [SEL_W-1:0]     sel;
  } op_payload_t;

endpackage

// File: rtl/alu_operand_loader_byte_assembler.sv
// alu_byte_assembler: collects four bytes into a 32-bit little-endian word.
// Ports:
//   clk, rst      - clock, async active-high reset
//   clr           - synchronous clear of counter and partial word
//   en            - a byte is accepted this cycle
//   in_byte       - byte being accepted
//   word_c        - assembled word including the current byte (valid with done_c)
//   done_c        - high on the cycle the 4th byte is accepted
module alu_byte_assembler
  import alu_operand_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [BYTE_W-1:0]    in_byte,
  output logic [OPERAND_W-1:0] word_c,
  output logic                 done_c
);

  localparam int unsigned PART_W = OPERAND_W - BYTE_W;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PART_W-1:0] part_q, part_d;

  // Bytes enter at the top and shift down, so the first byte ends up in 7:0.
  always_comb begin
    cnt_d  = cnt_q;
    part_d = part_q;
    if (clr) begin
      cnt_d  = '0;
      part_d = '0;
    end else if (en) begin
      cnt_d  = cnt_q + CNT_W'(1);
      part_d = {in_byte, part_q[PART_W-1:BYTE_W]};
    end
  end

  assign word_c = {in_byte, part_q};
  assign done_c = en && !clr && (cnt_q == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      part_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      part_q <= part_d;
    end
  end

endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: parses a byte-serial command stream into ALU operations.
// Frame: opcode byte (bits 2:0 select), 4 bytes of a, 4 bytes of b, LE.
// Optional feature macro ALU_LOADER_CHAIN_EN: opcode bit 7 skips operand a and
// reuses the result captured at the previous op transfer (5-byte frame).
// Ports:
//   clk, rst              - clock, async active-high reset
//   in_data/in_valid/in_ready - byte input handshake
//   flush                 - synchronous abort of the current frame
//   op_a/op_b/op_sel      - registered operation payload
//   op_valid/op_ready     - operation handshake to the ALU stage
//   res_in                - ALU result, captured on op transfer (chain build)
//   ops_done              - wrapping count of completed op transfers
module alu_operand_loader
  import alu_operand_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BYTE_W-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [OPERAND_W-1:0] op_a,
  output logic [OPERAND_W-1:0] op_b,
  output logic [SEL_W-1:0]     op_sel,
  output logic                 op_valid,
  input  logic                 op_ready,
  input  logic [OPERAND_W-1:0] res_in,
  output logic [DONE_W-1:0]    ops_done
);

  state_e               state_q, state_d;
  op_payload_t          op_q, op_d;
  logic                 in_ready_q, in_ready_d;
  logic                 op_valid_q, op_valid_d;
  logic [DONE_W-1:0]    ops_done_q, ops_done_d;
  logic                 byte_xfer_c, op_xfer_c;
  logic                 en_a_c, en_b_c, clr_a_c, clr_b_c;
  logic                 done_a_c, done_b_c;
  logic [OPERAND_W-1:0] word_a_c, word_b_c;

`ifdef ALU_LOADER_CHAIN_EN
  logic [OPERAND_W-1:0] last_res_q, last_res_d;
`else
  logic unused_res_in;
  assign unused_res_in = ^res_in;
`endif

  // Flush wins over a byte arriving in the same cycle.
  assign byte_xfer_c = in_valid && in_ready_q && !flush;
  assign op_xfer_c   = op_valid_q && op_ready;

  // Each assembler is held clear outside its own state, so it starts at 0 on entry.
  assign en_a_c  = byte_xfer_c && (state_q == LOAD_A);
  assign en_b_c  = byte_xfer_c && (state_q == LOAD_B);
  assign clr_a_c = flush || (state_q != LOAD_A);
  assign clr_b_c = flush || (state_q != LOAD_B);

  alu_byte_assembler u_asm_a (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_a_c),
    .en      (en_a_c),
    .in_byte (in_data),
    .word_c  (word_a_c),
    .done_c  (done_a_c)
  );

  alu_byte_assembler u_asm_b (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_b_c),
    .en      (en_b_c),
    .in_byte (in_data),
    .word_c  (word_b_c),
    .done_c  (done_b_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ops_done_d = ops_done_q;
`ifdef ALU_LOADER_CHAIN_EN
    last_res_d = last_res_q;
`endif

    case (state_q)
      IDLE: begin
        if (byte_xfer_c) begin
          op_d.sel = in_data[SEL_W-1:0];
          state_d  = LOAD_A;
`ifdef ALU_LOADER_CHAIN_EN
          if (in_data[BYTE_W-1]) begin
            op_d.a  = last_res_q;
            state_d = LOAD_B;
          end
`endif
        end
      end
      LOAD_A: begin
        if (done_a_c) begin
          op_d.a  = word_a_c;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (done_b_c) begin
          op_d.b  = word_b_c;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (op_xfer_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A transfer coinciding with flush still completes.
    if (op_xfer_c) begin
      ops_done_d = ops_done_q + DONE_W'(1);
`ifdef ALU_LOADER_CHAIN_EN
      last_res_d = res_in;
`endif
    end

    if (flush) state_d = IDLE;

    in_ready_d = (state_d != ISSUE);
    op_valid_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      in_ready_q <= 1'b1;
      op_valid_q <= 1'b0;
      ops_done_q <= '0;
`ifdef ALU_LOADER_CHAIN_EN
      last_res_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      in_ready_q <= in_ready_d;
      op_valid_q <= op_valid_d;
      ops_done_q <= ops_done_d;
`ifdef ALU_LOADER_CHAIN_EN
      last_res_q <= last_res_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign op_valid = op_valid_q;
  assign op_a     = op_q.a;
  assign op_b     = op_q.b;
  assign op_sel   = op_q.sel;
  assign ops_done = ops_done_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Testbench for alu_operand_loader: directed frames, a frame-level model of
// expected operations and a per-cycle compare against the DUT outputs.
module tb_alu_operand_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  op_sel;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] res_in;
  logic [15:0] ops_done;

  always #5 clk = ~clk;

  alu_operand_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_sel   (op_sel),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .res_in   (res_in),
    .ops_done (ops_done)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  exp_t        exp_q[$];
  int          xfer_cyc[$];
  logic [15:0] m_count  = '0;
  logic [15:0] m_offset = '0;
  logic [31:0] m_last   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: every cycle, outputs must match the oldest complete frame not yet taken.
  task automatic monitor();
    exp_t        e;
    logic [15:0] exp_done;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_op_valid", 32'(op_valid), 32'd0);
        chk("rst_ops_done", 32'(ops_done), 32'd0);
        exp_q.delete();
        m_count = '0;
        m_last  = '0;
      end else begin
        exp_done = m_count + m_offset;
        chk("ops_done", 32'(ops_done), 32'(exp_done));
        chk("in_ready_vs_valid", 32'(in_ready), 32'(!op_valid));
        if (op_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_op_valid", 32'(op_valid), 32'd0);
          end else begin
            e = exp_q[0];
            chk("op_a", op_a, e.a);
            chk("op_b", op_b, e.b);
            chk("op_sel", 32'(op_sel), 32'(e.sel));
            if (op_ready) begin
              void'(exp_q.pop_front());
              m_count = m_count + 16'd1;
              m_last  = res_in;
              xfer_cyc.push_back(cyc);
            end else if (flush) begin
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n        = 0;
    in_data  = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        chk("in_ready_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] opc, input logic [31:0] a,
                            input logic [31:0] b, input bit expect_issue);
    exp_t e;
    bit   chain;
    chain = 1'b0;
`ifdef ALU_LOADER_CHAIN_EN
    chain = opc[7];
`endif
    e.a   = chain ? m_last : a;
    e.b   = b;
    e.sel = opc[2:0];
    send_byte(opc);
    if (!chain) for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8]);
    if (expect_issue) exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    m_offset = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic stimulus();
    rst = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0;
    op_ready = 1'b1; res_in = 32'h0000_0010;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_op_valid", 32'(op_valid), 32'd0);
    chk("reset_op_a", op_a, 32'd0);
    chk("reset_ops_done", 32'(ops_done), 32'd0);

    // Basic frame, immediate acceptance.
    send_frame(8'h00, 32'h1234_5678, 32'h0000_0001, 1'b1);
    chk("t1_op_valid", 32'(op_valid), 32'd1);
    chk("t1_op_a", op_a, 32'h1234_5678);
    chk("t1_op_b", op_b, 32'h0000_0001);
    chk("t1_op_sel", 32'(op_sel), 32'd0);
    chk("t1_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("t1_valid_one_cycle", 32'(op_valid), 32'd0);
    chk("t1_ops_done", 32'(ops_done), 32'd1);

    // Backpressure for 5 cycles, transfer on the 6th.
    op_ready = 1'b0;
    send_frame(8'h00, 32'h1234_5678, 32'h0000_0001, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 32'(op_valid), 32'd1);
      chk("t2_hold_in_ready", 32'(in_ready), 32'd0);
      chk("t2_hold_a", op_a, 32'h1234_5678);
      tick();
    end
    op_ready = 1'b1;
    tick();
    chk("t2_released", 32'(op_valid), 32'd0);
    chk("t2_ops_done", 32'(ops_done), 32'd2);

    // Reset while in ISSUE discards the frame.
    op_ready = 1'b0;
    send_frame(8'h04, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
    chk("t4_in_issue", 32'(op_valid), 32'd1);
    rst = 1'b1;
    m_offset = '0;
    #1;
    chk("t4_rst_valid_async", 32'(op_valid), 32'd0);
    chk("t4_rst_done_async", 32'(ops_done), 32'd0);
    tick();
    rst = 1'b0;
    op_ready = 1'b1;
    tick();

    // Flush after 3 a-bytes, with a byte colliding with flush, then a new frame.
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    in_data = 8'hEE; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    send_frame(8'h05, 32'hCAFE_BABE, 32'h1122_3344, 1'b1);
    chk("t3_op_a", op_a, 32'hCAFE_BABE);
    chk("t3_op_sel", 32'(op_sel), 32'd5);
    tick();
    chk("t3_ops_done", 32'(ops_done), 32'd1);

    // Flush coincident with an op transfer still counts.
    send_frame(8'h01, 32'h0000_00AA, 32'h0000_0055, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_flush_xfer_done", 32'(ops_done), 32'd2);
    chk("t5_flush_idle", 32'(in_ready), 32'd1);

`ifdef ALU_LOADER_CHAIN_EN
    // Chained frame reuses the previous result as operand a.
    res_in = 32'h0000_0010;
    send_frame(8'h00, 32'h0000_0005, 32'h0000_0006, 1'b1);
    tick();
    res_in = 32'h0000_0000;
    send_frame(8'h81, 32'h0000_0000, 32'h0000_0002, 1'b1);
    chk("t6_chain_valid", 32'(op_valid), 32'd1);
    chk("t6_chain_a", op_a, 32'h0000_0010);
    chk("t6_chain_b", op_b, 32'h0000_0002);
    chk("t6_chain_sel", 32'(op_sel), 32'd1);
    tick();
`else
    // Bit 7 is ignored: still a full 9-byte frame.
    send_frame(8'h83, 32'h0000_00F0, 32'h0000_000F, 1'b1);
    chk("t6_bit7_a", op_a, 32'h0000_00F0);
    chk("t6_bit7_sel", 32'(op_sel), 32'd3);
    tick();
`endif

    // Back-to-back frames: one op per 10 cycles.
    xfer_cyc.delete();
    send_frame(8'h06, 32'h0000_0001, 32'h0000_0004, 1'b1);
    send_frame(8'h07, 32'h8000_0000, 32'h0000_0001, 1'b1);
    repeat (2) tick();
    if (xfer_cyc.size() < 2) chk("t7_b2b_count", 32'(xfer_cyc.size()), 32'd2);
    else chk("t7_b2b_period", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd10);

    // Counter wrap 0xFFFF -> 0x0000.
    force dut.ops_done_q = 16'hFFFF;
    m_offset = 16'hFFFF - m_count;
    tick();
    release dut.ops_done_q;
    chk("t8_preload", 32'(ops_done), 32'h0000_FFFF);
    send_frame(8'h03, 32'h0F0F_0F0F, 32'h00FF_00FF, 1'b1);
    tick();
    chk("t8_wrap", 32'(ops_done), 32'd0);

    do_reset();
    chk("final_reset_done", 32'(ops_done), 32'd0);
    repeat (2) tick();
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
